imem_loader: RTL and testbench
==============================

# imem_loader

Byte-serial instruction-memory loader between the pad ring and the `digital` core. It takes the raw port-A byte bus, the `sclk` byte strobe and the `modesel_0` load-enable pin, all asynchronous to `clk`. It synchronises them and assembles a start address plus a stream of 40-bit instruction words. It issues one single-cycle `imem_write` per completed word, with auto-incrementing address, and holds the core in reset while loading is active.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction memory address width.
- `DATA_W`, default 40: instruction word width. Must be a multiple of 8.
- `BYTES_PER_WORD`, default `DATA_W/8` = 5: data bytes per word.

Ports:
- `clk`  in  1  core clock. The only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  byte strobe from pad, asynchronous. A byte is taken on each rising edge.
- `load_en`  in  1  loader enable, driven from the `modesel_0` pad, asynchronous.
- `data_in`  in  8  port-A byte from pads, asynchronous. Must be stable from the `sclk` rise until 4 `clk` cycles after it.
- `imem_write_adr`  out  ADDR_W  write address, valid while `imem_write` is high.
- `imem_in`  out  DATA_W  write data, valid while `imem_write` is high.
- `imem_write`  out  1  one-cycle write pulse.
- `core_reset`  out  1  reset to the core, high while loading.
- `word_count`  out  ADDR_W+1  words written since the last `load_en` rise. Saturates at 2^ADDR_W.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Synchronisation:
  - `sclk` and `load_en` each pass through a 2-flop synchroniser, then an edge-detect register.
  - `strobe` is the one-cycle pulse on the synchronised `sclk` rise.
  - `data_in` passes through a 2-flop bank and is sampled on the `strobe` cycle.
- State machine: IDLE, ADDR_HI, ADDR_LO, DATA.
  - IDLE -> ADDR_HI on the synchronised `load_en` rise. `word_count` clears to 0.
  - ADDR_HI: on `strobe`, `addr[ADDR_W-1:8]` <= byte bits `[ADDR_W-9:0]`; higher byte bits are ignored. Go to ADDR_LO.
  - ADDR_LO: on `strobe`, `addr[7:0]` <= byte. Go to DATA with byte index 0.
  - DATA:
    - On each `strobe`, the shift register is updated as `shreg <= {shreg[DATA_W-9:0], byte}`, so the first byte received becomes the MSB of the word.
    - The byte index increments on each `strobe`.
    - On the strobe that completes byte `BYTES_PER_WORD-1`, register `imem_in <= {shreg[DATA_W-9:0], byte}` and `imem_write_adr <= addr`, and set `imem_write` for the next cycle.
    - In that same cycle, `addr` increments modulo 2^ADDR_W (1023 wraps to 0), the byte index returns to 0 and `word_count` increments (saturating).
    - The FSM stays in DATA.
  - Any state -> IDLE on the synchronised `load_en` fall. A partial word (index ≠ 0) is discarded; no write is issued.
- Strobes in IDLE are ignored.
- `core_reset` = `reset` OR synchronised `load_en`. It is registered.
- `busy` = (state ≠ IDLE).
- `imem_in` and `imem_write_adr` hold their last written value between pulses.

## Timing
- Reset values (after `reset` sampled high):
  - state = IDLE.
  - `imem_write` = 0, `imem_in` = 0, `imem_write_adr` = 0.
  - `word_count` = 0, `busy` = 0, `core_reset` = 1.
  - Synchronisers and shift register = 0.
- Reset mid-operation aborts the load immediately. No write is issued, even if one was pending.
- Latency:
  - `sclk` rise to `strobe`: 3 clk edges.
  - Final-byte `strobe` to `imem_write` high: 1 cycle.
  - `load_en` pin change to `busy`/state change: 3 cycles.
  - `load_en` pin change to `core_reset` change: 3 cycles.
- `sclk` high and low phases must each be ≥ 2 clk periods. Consecutive strobes are therefore ≥ 4 cycles apart, and `imem_write` never overlaps a strobe.
- Simultaneous events:
  - A `load_en` fall in the same cycle as the final-byte strobe: the fall wins and no write is issued.
  - If a write pulse is already registered when the fall occurs, that pulse still completes.
- A `load_en` rise while already non-IDLE cannot occur (a fall must come first). Re-entering from IDLE always restarts at ADDR_HI.

## Test plan
- Reset: assert `reset` for 2 cycles with `load_en`=1 and `sclk` toggling -> all outputs at reset values, `core_reset`=1, no `imem_write`.
- Single word: `load_en`↑, bytes 0x01, 0x23, then 0xDE 0xAD 0xBE 0xEF 0x42 -> exactly one `imem_write` with `imem_write_adr`=0x123 and `imem_in`=0xDEADBEEF42, 4 cycles after the 7th `sclk`↑; `word_count`=1.
- Address wrap: start address 0x3FF (bytes 0x03, 0xFF), send 2 words -> writes at 0x3FF then 0x000; `word_count`=2.
- Abort: start at 0x010, send 1 full word plus 3 bytes, drop `load_en` -> one write only (0x010); `busy`=0 and `core_reset`=0 within 3 cycles; no further writes.
- Reload: after the abort, raise `load_en` again with address 0x000 and 1 word -> write at 0x000, `word_count` restarts at 1, and the stale partial bytes do not appear in `imem_in`.
- Masking: address-high byte 0xFE -> address bits [9:8]=2'b10. Strobes while IDLE produce no state change and no write.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-memory write bus driven by the byte-serial loader.
//   imem_write_adr  write address, valid while imem_write is high
//   imem_in         write data, valid while imem_write is high
//   imem_write      one-cycle write strobe
// master = loader side (drives), slave = memory side (receives).
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 40
);
    logic [ADDR_W-1:0] imem_write_adr;
    logic [DATA_W-1:0] imem_in;
    logic              imem_write;

    modport master (output imem_write_adr, output imem_in, output imem_write);
    modport slave  (input  imem_write_adr, input  imem_in, input  imem_write);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-serial instruction-memory loader.
// Synchronises the pad byte bus, its sclk strobe and the load enable into clk,
// collects a 2-byte start address followed by BYTES_PER_WORD-byte words (first
// byte = MSB), and issues one imem_write pulse per completed word with an
// auto-incrementing address. The core is held in reset while loading.
//   clk, reset   core clock, synchronous active-high reset
//   sclk         async byte strobe (byte taken on rise)
//   load_en      async loader enable (modesel_0 pad)
//   data_in      async byte bus
//   imem         write bus (master)
//   core_reset   registered reset | synchronised load_en
//   word_count   words written since last load_en rise, saturating at 2^ADDR_W
//   busy         state != IDLE
// Assumes ADDR_W > 8 and DATA_W >= 16.
module imem_loader #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 40,
    parameter int BYTES_PER_WORD = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              load_en,
    input  logic [7:0]        data_in,
    imem_loader_if.master     imem,
    output logic              core_reset,
    output logic [ADDR_W:0]   word_count,
    output logic              busy
);
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]   WC_MAX   = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;
    state_t state, next_state;

    logic              sclk_s1, sclk_s2, sclk_d, strobe;
    logic              le_s1, le_s2, le_d;
    logic [7:0]        data_s1, data_s2;
    logic              le_rise, le_fall, word_done;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    // Only the low DATA_W-8 bits are kept: the oldest byte is consumed directly
    // into imem_in on the completing strobe, so it never needs to be stored.
    logic [DATA_W-9:0] shreg;

    assign le_rise = le_s2 & ~le_d;
    assign le_fall = le_d & ~le_s2;
    assign busy    = (state != IDLE);

    // Synchronisers; strobe is registered so it lands 3 edges after the sclk rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0; strobe <= 1'b0;
            le_s1   <= 1'b0; le_s2   <= 1'b0; le_d   <= 1'b0;
            data_s1 <= '0;   data_s2 <= '0;
        end else begin
            sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            strobe  <= sclk_s2 & ~sclk_d;
            le_s1   <= load_en; le_s2   <= le_s1;   le_d   <= le_s2;
            data_s1 <= data_in; data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A load_en fall overrides everything, including a completing strobe.
    always_comb begin
        next_state = state;
        word_done  = 1'b0;
        if (le_fall) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (le_rise) next_state = ADDR_HI;
                ADDR_HI: if (strobe)  next_state = ADDR_LO;
                ADDR_LO: if (strobe)  next_state = DATA;
                DATA:    word_done = strobe && (idx == LAST_IDX);
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr                <= '0;
            idx                 <= '0;
            shreg               <= '0;
            word_count          <= '0;
            core_reset          <= 1'b1;
            imem.imem_write     <= 1'b0;
            imem.imem_in        <= '0;
            imem.imem_write_adr <= '0;
        end else begin
            core_reset      <= le_s2;
            imem.imem_write <= word_done;
            if (state == IDLE && le_rise) word_count <= '0;
            if (strobe && !le_fall) begin
                case (state)
                    ADDR_HI: addr[ADDR_W-1:8] <= data_s2[ADDR_W-9:0];
                    ADDR_LO: begin
                        addr[7:0] <= data_s2;
                        idx       <= '0;
                    end
                    DATA: begin
                        shreg <= {shreg[DATA_W-17:0], data_s2};
                        if (idx == LAST_IDX) begin
                            imem.imem_in        <= {shreg, data_s2};
                            imem.imem_write_adr <= addr;
                            addr                <= addr + 1'b1;
                            idx                 <= '0;
                            if (word_count != WC_MAX) word_count <= word_count + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, sclk, load_en;
    logic [7:0]  data_in;
    logic        core_reset, busy;
    logic [10:0] word_count;
    int          n_cmp = 0, n_err = 0, wr_cnt = 0;
    logic [5:0]  wr_trace;

    imem_loader_if #(.ADDR_W(10), .DATA_W(40)) imem ();

    imem_loader dut (
        .clk(clk), .reset(reset), .sclk(sclk), .load_en(load_en),
        .data_in(data_in), .imem(imem), .core_reset(core_reset),
        .word_count(word_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem.imem_write === 1'b1) wr_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte: sclk high 3 cycles, low 3 cycles; imem_write sampled on each
    // of the 6 following negedges (bit k-1 = k-th negedge).
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        sclk    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wr_trace[k] = imem.imem_write;
            if (k == 2) sclk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [39:0] w);
        for (int i = 4; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    // Change load_en and check busy/core_reset follow on exactly the 3rd edge.
    task automatic set_load(input logic v);
        @(negedge clk);
        load_en = v;
        repeat (2) @(negedge clk);
        chk("busy_pre",  busy, !v);
        @(negedge clk);
        chk("busy_post", busy, v);
        chk("core_rst",  core_reset, v);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b1; sclk = 1'b0; data_in = 8'h00;
        repeat (4) begin @(negedge clk); sclk = ~sclk; end
        chk("rst_wr",   imem.imem_write, 0);
        chk("rst_adr",  imem.imem_write_adr, 0);
        chk("rst_dat",  imem.imem_in, 0);
        chk("rst_wc",   word_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core", core_reset, 1);
        load_en = 1'b0; sclk = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_core", core_reset, 0);
        chk("rst_nowr",  wr_cnt, 0);

        // Strobes while idle are ignored
        send_byte(8'h55); send_byte(8'hAA);
        chk("idle_busy", busy, 0);
        chk("idle_nowr", wr_cnt, 0);

        // Single word at 0x123
        set_load(1'b1);
        send_byte(8'h01); send_byte(8'h23);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("w1_nowr_early", wr_cnt, 0);
        send_byte(8'h42);
        chk("w1_trace", wr_trace, 6'b001000);
        chk("w1_cnt",   wr_cnt, 1);
        chk("w1_adr",   imem.imem_write_adr, 10'h123);
        chk("w1_dat",   imem.imem_in, 40'hDEADBEEF42);
        chk("w1_wc",    word_count, 1);
        set_load(1'b0);

        // Address wrap 0x3FF -> 0x000
        set_load(1'b1);
        send_byte(8'h03); send_byte(8'hFF);
        send_word(40'h1122334455);
        chk("wr_adr0", imem.imem_write_adr, 10'h3FF);
        chk("wr_dat0", imem.imem_in, 40'h1122334455);
        send_word(40'h66778899AA);
        chk("wr_adr1", imem.imem_write_adr, 10'h000);
        chk("wr_dat1", imem.imem_in, 40'h66778899AA);
        chk("wr_wc",   word_count, 2);
        chk("wr_cnt",  wr_cnt, 3);
        set_load(1'b0);

        // Abort with a partial word pending
        set_load(1'b1);
        send_byte(8'h00); send_byte(8'h10);
        send_word(40'h0102030405);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        set_load(1'b0);
        repeat (10) @(negedge clk);
        chk("ab_cnt", wr_cnt, 4);
        chk("ab_adr", imem.imem_write_adr, 10'h010);
        chk("ab_dat", imem.imem_in, 40'h0102030405);

        // Reload after abort: fresh word, count restarts
        set_load(1'b1);
        chk("rl_wc0", word_count, 0);
        send_byte(8'h00); send_byte(8'h00);
        send_word(40'hC0C1C2C3C4);
        chk("rl_adr", imem.imem_write_adr, 10'h000);
        chk("rl_dat", imem.imem_in, 40'hC0C1C2C3C4);
        chk("rl_wc",  word_count, 1);
        set_load(1'b0);

        // High address byte masked to ADDR_W-8 bits
        set_load(1'b1);
        send_byte(8'hFE); send_byte(8'h34);
        send_word(40'hFEEDFACE01);
        chk("mk_adr", imem.imem_write_adr, 10'h234);
        chk("mk_dat", imem.imem_in, 40'hFEEDFACE01);
        set_load(1'b0);
        chk("mk_cnt", wr_cnt, 6);

        // Reset mid-load aborts with no write
        set_load(1'b1);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk); reset = 1'b1; load_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_wc",   word_count, 0);
        chk("mr_dat",  imem.imem_in, 0);
        chk("mr_core", core_reset, 1);
        reset = 1'b0;
        send_byte(8'h55);
        repeat (5) @(negedge clk);
        chk("mr_cnt",  wr_cnt, 6);
        chk("mr_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
